// File: rtl/fifo_txn_checker_if.sv
// Port bundle of the monitored 1R1W FIFO. The DUT side drives ready/valid/data_o.
// The stimulus drives valid_i/data_i/yumi_i. The checker only observes.
interface fifo_txn_checker_if #(
  parameter int width_p = 8
);
  logic               valid_i;
  logic               ready_o;
  logic [width_p-1:0] data_i;
  logic               valid_o;
  logic [width_p-1:0] data_o;
  logic               yumi_i;

  modport master (
    input  valid_i, data_i, yumi_i,
    output ready_o, valid_o, data_o
  );

  modport slave (
    input valid_i, ready_o, data_i, valid_o, data_o, yumi_i
  );
endinterface

// File: rtl/fifo_txn_checker.sv
// Passive FIFO checker. It keeps a shadow FIFO and flags reset, data and stimulus errors.
// It also accumulates sticky coverage indexed by occupancy.
module fifo_txn_checker #(
  parameter int width_p = 8,
  parameter int cap_p   = 8,
  parameter int cnt_w_p = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       cov_clr_i,
  fifo_txn_checker_if.slave          mon,
  output logic                       res_err_o,
  output logic                       data_err_o,
  output logic                       tb_err_o,
  output logic [$clog2(cap_p+1)-1:0] occ_o,
  output logic [cap_p-1:0]           enq_cov_o,
  output logic [cap_p-1:0]           deq_cov_o,
  output logic [cap_p-2:0]           both_cov_o,
  output logic [cnt_w_p-1:0]         res_err_cnt_o,
  output logic [cnt_w_p-1:0]         data_err_cnt_o
);
  localparam int OCC_W = $clog2(cap_p+1);
  localparam int PTR_W = $clog2(cap_p);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(cap_p);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(cap_p-1);

  typedef enum logic {S_CHK, S_RUN} state_t;
  state_t r_state, w_state_next;

  logic [width_p-1:0] r_mem [cap_p];
  logic [PTR_W-1:0]   r_wptr, r_rptr;
  logic [OCC_W-1:0]   r_occ, w_occ_next;
  logic               r_res_err, r_data_err, r_tb_err;
  logic               w_res_err, w_data_err, w_tb_err;
  logic               w_enq, w_deq, w_empty, w_full, w_wr, w_rd;
  logic [width_p-1:0] w_head;

  logic [cap_p-1:0]   r_enq_cov, r_deq_cov, w_enq_set, w_deq_set;
  logic [cap_p-2:0]   r_both_cov, w_both_set;
  logic [cnt_w_p-1:0] r_res_cnt, r_data_cnt;

  assign w_enq   = mon.valid_i & mon.ready_o;
  assign w_deq   = mon.valid_o & mon.yumi_i;
  assign w_empty = (r_occ == '0);
  assign w_full  = (r_occ == OCC_FULL);
  assign w_head  = r_mem[r_rptr];
  // A full shadow still accepts the write when the head leaves in the same cycle.
  assign w_rd    = w_deq & ~w_empty;
  assign w_wr    = w_enq & (~w_full | w_rd);

  always_comb begin
    w_state_next = r_state;
    w_res_err    = 1'b0;
    case (r_state)
      S_CHK: begin
        w_res_err    = ~(mon.ready_o & ~mon.valid_o);
        w_state_next = S_RUN;
      end
      default: w_state_next = S_RUN;
    endcase
  end

  always_comb begin
    w_data_err = (w_deq & (w_empty | (mon.data_o != w_head)))
               | (mon.valid_o != ~w_empty)
               | (mon.ready_o == w_full);
    w_tb_err   = mon.yumi_i & ~mon.valid_o;
    w_occ_next = r_occ;
    if (w_wr & ~w_rd)
      w_occ_next = r_occ + 1'b1;
    else if (w_rd & ~w_wr)
      w_occ_next = r_occ - 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state    <= S_CHK;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_occ      <= '0;
      r_res_err  <= 1'b0;
      r_data_err <= 1'b0;
      r_tb_err   <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_occ      <= w_occ_next;
      r_res_err  <= w_res_err;
      r_data_err <= w_data_err;
      r_tb_err   <= w_tb_err;
      if (w_wr)
        r_wptr <= (r_wptr == PTR_LAST) ? '0 : r_wptr + 1'b1;
      if (w_rd)
        r_rptr <= (r_rptr == PTR_LAST) ? '0 : r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_wr)
      r_mem[r_wptr] <= mon.data_i;
  end

  genvar gi;
  generate
    for (gi = 0; gi < cap_p; gi++) begin : g_cov
      assign w_enq_set[gi] = w_enq & ~w_deq & (r_occ == OCC_W'(gi));
      assign w_deq_set[gi] = w_deq & ~w_enq & (r_occ == OCC_W'(gi+1));
    end
    for (gi = 0; gi < cap_p-1; gi++) begin : g_both
      assign w_both_set[gi] = w_enq & w_deq & (r_occ == OCC_W'(gi+1));
    end
  endgenerate

  // Coverage and counters survive reset; only cov_clr_i clears them.
  always_ff @(posedge clk_i) begin
    if (cov_clr_i) begin
      r_enq_cov  <= '0;
      r_deq_cov  <= '0;
      r_both_cov <= '0;
      r_res_cnt  <= '0;
      r_data_cnt <= '0;
    end else begin
      if (reset_n_i) begin
        r_enq_cov  <= r_enq_cov  | w_enq_set;
        r_deq_cov  <= r_deq_cov  | w_deq_set;
        r_both_cov <= r_both_cov | w_both_set;
      end
      if (r_res_err && (r_res_cnt != '1))
        r_res_cnt <= r_res_cnt + 1'b1;
      if (r_data_err && (r_data_cnt != '1))
        r_data_cnt <= r_data_cnt + 1'b1;
    end
  end

  assign res_err_o      = r_res_err;
  assign data_err_o     = r_data_err;
  assign tb_err_o       = r_tb_err;
  assign occ_o          = r_occ;
  assign enq_cov_o      = r_enq_cov;
  assign deq_cov_o      = r_deq_cov;
  assign both_cov_o     = r_both_cov;
  assign res_err_cnt_o  = r_res_cnt;
  assign data_err_cnt_o = r_data_cnt;
endmodule
